// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset controller for the Pong design. It synchronizes the release of
// the asynchronous board reset and then releases the subsystem resets one at a
// time, in ascending order:
//   stage 0 - VGA timing
//   stage 1 - game logic
//   stage 2 - score/display
// A synchronous soft-reset request (new game / serve) re-runs the whole
// sequence. sys_ready reports that every stage is out of reset.
//
// Optional feature (macro RESET_SEQ_ACK_WAIT_EN):
//   Each release after the first also waits for the previous stage to
//   acknowledge through stage_ack[index]. A stage that does not acknowledge
//   within ACK_TIMEOUT cycles sets its sticky fault bit, and the sequence
//   advances anyway. Without the macro, stage_ack is ignored, fault is tied
//   to 0, and every release is timed by GAP_CYCLES alone.
//
// Ports:
//   clk           in   system clock
//   reset         in   board reset, asynchronous, active-high
//   soft_rst_req  in   single-cycle synchronous request to re-run the sequence
//   stage_ack     in   [NUM_STAGES] per-stage "out of reset OK" level
//   stage_rst     out  [NUM_STAGES] per-stage reset, active-high, registered
//   sys_ready     out  all stages released and sequence complete, registered
//   busy          out  sequencer in HOLD or RELEASE, registered
//   fault         out  [NUM_STAGES] sticky per-stage ack-timeout flags
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  sys_ready,
   output logic                  busy,
   output logic [NUM_STAGES-1:0] fault
);

   // The counter has to reach the largest limit it is compared against.
   localparam int CNT_MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > ACK_TIMEOUT) ? CNT_MAX_A : ACK_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                  state_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic [CNT_W-1:0]        cnt_next;
   logic [IDX_W-1:0]        idx_reg;
   logic [NUM_STAGES-1:0]   stage_rst_reg;
   logic                    sys_ready_reg;
   logic                    busy_reg;
   logic [1:0]              sync_reg;
   logic                    rst_sync;
   logic                    advance;
   logic                    set_fault;
   logic [NUM_STAGES-1:0]   release_mask;
   logic [NUM_STAGES-1:0]   index_mask;

   // Release synchronizer. Clearing is asynchronous. The set value takes two
   // clk edges to propagate, so the FSM starts counting on the 3rd edge after
   // the board reset deasserts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], 1'b1};
      end
   end

   assign rst_sync = ~sync_reg[1];

   // release_mask selects the stage that follows the current index.
   // index_mask selects the current index, which is used for fault capture.
   assign release_mask[0] = 1'b0;
   assign index_mask[0]   = (idx_reg == IDX_W'(0));
   generate
      for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_masks
         assign release_mask[gi] = (idx_reg == IDX_W'(gi - 1));
         assign index_mask[gi]   = (idx_reg == IDX_W'(gi));
      end
   endgenerate

`ifdef RESET_SEQ_ACK_WAIT_EN
   logic [NUM_STAGES-1:0] fault_reg;
   logic                  ack_now;
   logic                  timed_out;

   always_comb begin
      ack_now   = stage_ack[idx_reg];
      // The counter saturates at ACK_TIMEOUT. It never sits there in practice,
      // because reaching the timeout forces an advance.
      if (cnt_reg >= CNT_W'(ACK_TIMEOUT)) begin
         cnt_next = cnt_reg;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
      timed_out = (cnt_next >= CNT_W'(ACK_TIMEOUT));
      advance   = ((cnt_next >= CNT_W'(GAP_CYCLES)) && ack_now) || timed_out;
      // A fault is flagged only when the timeout forces the advance. An ack
      // that arrives on the timeout edge still counts as success.
      set_fault = timed_out && !ack_now;
   end

   assign fault = fault_reg;
`else
   logic unused_ack;

   assign unused_ack = ^stage_ack;

   always_comb begin
      cnt_next  = cnt_reg + CNT_W'(1);
      advance   = (cnt_next >= CNT_W'(GAP_CYCLES));
      set_fault = 1'b0;
   end

   assign fault = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_HOLD;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         stage_rst_reg <= '1;
         sys_ready_reg <= 1'b0;
         busy_reg      <= 1'b1;
`ifdef RESET_SEQ_ACK_WAIT_EN
         fault_reg     <= '0;
`endif
      end else begin
         case (state_reg)
            ST_HOLD: begin
               // soft_rst_req is ignored here. The hold count keeps running.
               if (rst_sync) begin
                  cnt_reg <= '0;
               end else if (cnt_next == CNT_W'(HOLD_CYCLES)) begin
                  stage_rst_reg[0] <= 1'b0;
                  idx_reg          <= '0;
                  cnt_reg          <= '0;
                  state_reg        <= ST_RELEASE;
               end else begin
                  cnt_reg <= cnt_next;
               end
            end

            ST_RELEASE, ST_RUN: begin
               // A soft reset takes priority over any advance on the same edge.
               if (soft_rst_req) begin
                  state_reg     <= ST_HOLD;
                  cnt_reg       <= '0;
                  idx_reg       <= '0;
                  stage_rst_reg <= '1;
                  sys_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
               end else if (state_reg == ST_RELEASE) begin
                  if (advance) begin
`ifdef RESET_SEQ_ACK_WAIT_EN
                     if (set_fault) begin
                        fault_reg <= fault_reg | index_mask;
                     end
`endif
                     cnt_reg <= '0;
                     if (idx_reg == IDX_W'(NUM_STAGES - 1)) begin
                        sys_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_RUN;
                     end else begin
                        stage_rst_reg <= stage_rst_reg & ~release_mask;
                        idx_reg       <= idx_reg + IDX_W'(1);
                     end
                  end else begin
                     cnt_reg <= cnt_next;
                  end
               end
            end

            default: begin
               state_reg <= ST_HOLD;
            end
         endcase
      end
   end

   // Without the ack-wait feature, set_fault and index_mask have no sink.
   // Folding them in here keeps them from being reported as unused.
`ifndef RESET_SEQ_ACK_WAIT_EN
   logic unused_fault_path;

   assign unused_fault_path = set_fault | (^index_mask);
`endif

   assign stage_rst = stage_rst_reg;
   assign sys_ready = sys_ready_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed testbench for reset_sequencer with the default timing
// (HOLD_CYCLES=16, GAP_CYCLES=4, NUM_STAGES=3) and ACK_TIMEOUT=20.
// Edge numbers count from 1 at the first rising clk edge after the board
// reset deasserts. With the defaults:
//   stage_rst[0] falls at edge 18
//   stage_rst[1] falls at edge 22
//   stage_rst[2] falls at edge 26
//   sys_ready rises at edge 30
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       clk          = 1'b0;
   logic       reset        = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic [2:0] stage_ack    = 3'b000;
   logic [2:0] stage_rst;
   logic       sys_ready;
   logic       busy;
   logic [2:0] fault;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .NUM_STAGES  (3),
      .HOLD_CYCLES (16),
      .GAP_CYCLES  (4),
      .ACK_TIMEOUT (20)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .soft_rst_req (soft_rst_req),
      .stage_ack    (stage_ack),
      .stage_rst    (stage_rst),
      .sys_ready    (sys_ready),
      .busy         (busy),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   // Expected stage_rst, where k is the number of edges relative to the
   // stage 0 release.
   function automatic logic [2:0] exp_rst(input int k);
      if (k < 0)      return 3'b111;
      else if (k < 4) return 3'b110;
      else if (k < 8) return 3'b100;
      else            return 3'b000;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic assert_reset;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   // Deasserts reset at a falling edge, so the next rising edge is edge 1.
   task automatic release_reset;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      assert_reset();
      checks += 4;
      if (stage_rst !== 3'b111) begin errors++; $display("FAIL reset_stage_rst got=%b exp=111", stage_rst); end
      if (sys_ready !== 1'b0)   begin errors++; $display("FAIL reset_sys_ready got=%b exp=0", sys_ready); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
      if (fault !== 3'b000)     begin errors++; $display("FAIL reset_fault got=%b exp=000", fault); end
      repeat (5) tick();
      checks += 2;
      if (stage_rst !== 3'b111) begin errors++; $display("FAIL reset_hold_stage_rst got=%b exp=111", stage_rst); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL reset_hold_busy got=%b exp=1", busy); end
      $display("test_reset done: stage_rst=%b sys_ready=%b busy=%b fault=%b", stage_rst, sys_ready, busy, fault);
   endtask

   task automatic test_sequence;
      release_reset();
      for (int n = 1; n <= 32; n++) begin
         tick();
         checks += 3;
         if (stage_rst !== exp_rst(n - 18)) begin errors++; $display("FAIL seq_stage_rst edge=%0d got=%b exp=%b", n, stage_rst, exp_rst(n - 18)); end
         if (sys_ready !== (n >= 30))       begin errors++; $display("FAIL seq_sys_ready edge=%0d got=%b exp=%b", n, sys_ready, (n >= 30)); end
         if (busy !== (n < 30))             begin errors++; $display("FAIL seq_busy edge=%0d got=%b exp=%b", n, busy, (n < 30)); end
      end
      $display("test_sequence done: stage_rst=%b sys_ready=%b busy=%b", stage_rst, sys_ready, busy);
   endtask

   task automatic test_soft_in_run;
      logic [2:0] fault_before;
      fault_before = fault;
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      checks += 3;
      if (stage_rst !== 3'b111) begin errors++; $display("FAIL soft_run_stage_rst got=%b exp=111", stage_rst); end
      if (sys_ready !== 1'b0)   begin errors++; $display("FAIL soft_run_sys_ready got=%b exp=0", sys_ready); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL soft_run_busy got=%b exp=1", busy); end
      for (int m = 1; m <= 30; m++) begin
         tick();
         checks += 2;
         if (stage_rst !== exp_rst(m - 16)) begin errors++; $display("FAIL soft_run_seq_stage_rst edge=%0d got=%b exp=%b", m, stage_rst, exp_rst(m - 16)); end
         if (sys_ready !== (m >= 28))       begin errors++; $display("FAIL soft_run_seq_sys_ready edge=%0d got=%b exp=%b", m, sys_ready, (m >= 28)); end
      end
      checks++;
      if (fault !== fault_before) begin errors++; $display("FAIL soft_run_fault got=%b exp=%b", fault, fault_before); end
      $display("test_soft_in_run done: stage_rst=%b sys_ready=%b fault=%b", stage_rst, sys_ready, fault);
   endtask

   task automatic test_soft_in_hold;
      assert_reset();
      repeat (3) tick();
      release_reset();
      for (int n = 1; n <= 32; n++) begin
         if (n == 10) soft_rst_req = 1'b1;
         tick();
         soft_rst_req = 1'b0;
         checks += 2;
         if (stage_rst !== exp_rst(n - 18)) begin errors++; $display("FAIL soft_hold_stage_rst edge=%0d got=%b exp=%b", n, stage_rst, exp_rst(n - 18)); end
         if (sys_ready !== (n >= 30))       begin errors++; $display("FAIL soft_hold_sys_ready edge=%0d got=%b exp=%b", n, sys_ready, (n >= 30)); end
      end
      $display("test_soft_in_hold done: stage_rst=%b sys_ready=%b", stage_rst, sys_ready);
   endtask

   task automatic test_async_mid;
      assert_reset();
      repeat (3) tick();
      release_reset();
      repeat (20) tick();
      checks++;
      if (stage_rst !== 3'b110) begin errors++; $display("FAIL mid_pre_stage_rst got=%b exp=110", stage_rst); end
      // Assert reset between clock edges. The outputs must respond without a clk edge.
      #2;
      reset = 1'b1;
      #1;
      checks += 3;
      if (stage_rst !== 3'b111) begin errors++; $display("FAIL mid_async_stage_rst got=%b exp=111", stage_rst); end
      if (sys_ready !== 1'b0)   begin errors++; $display("FAIL mid_async_sys_ready got=%b exp=0", sys_ready); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL mid_async_busy got=%b exp=1", busy); end
      repeat (3) tick();
      release_reset();
      for (int n = 1; n <= 32; n++) begin
         tick();
         checks += 2;
         if (stage_rst !== exp_rst(n - 18)) begin errors++; $display("FAIL mid_rerun_stage_rst edge=%0d got=%b exp=%b", n, stage_rst, exp_rst(n - 18)); end
         if (busy !== (n < 30))             begin errors++; $display("FAIL mid_rerun_busy edge=%0d got=%b exp=%b", n, busy, (n < 30)); end
      end
      $display("test_async_mid done: stage_rst=%b sys_ready=%b busy=%b", stage_rst, sys_ready, busy);
   endtask

`ifdef RESET_SEQ_ACK_WAIT_EN
   task automatic test_ack_timeout;
      logic [2:0] er;
      logic [2:0] ef;
      assert_reset();
      stage_ack = 3'b001;
      repeat (3) tick();
      release_reset();
      for (int n = 1; n <= 64; n++) begin
         tick();
         er = (n < 18) ? 3'b111 : (n < 22) ? 3'b110 : (n < 42) ? 3'b100 : 3'b000;
         ef = (n < 42) ? 3'b000 : (n < 62) ? 3'b010 : 3'b110;
         checks += 3;
         if (stage_rst !== er)       begin errors++; $display("FAIL ack_to_stage_rst edge=%0d got=%b exp=%b", n, stage_rst, er); end
         if (fault !== ef)           begin errors++; $display("FAIL ack_to_fault edge=%0d got=%b exp=%b", n, fault, ef); end
         if (sys_ready !== (n >= 62)) begin errors++; $display("FAIL ack_to_sys_ready edge=%0d got=%b exp=%b", n, sys_ready, (n >= 62)); end
      end
      $display("test_ack_timeout done: stage_rst=%b fault=%b sys_ready=%b", stage_rst, fault, sys_ready);
   endtask

   task automatic test_ack_arrives;
      logic [2:0] er;
      assert_reset();
      stage_ack = 3'b001;
      repeat (3) tick();
      release_reset();
      for (int n = 1; n <= 40; n++) begin
         tick();
         // Raise the acks after edge 31, so they are first sampled at edge 32.
         if (n == 31) stage_ack = 3'b111;
         er = (n < 18) ? 3'b111 : (n < 22) ? 3'b110 : (n < 32) ? 3'b100 : 3'b000;
         checks += 3;
         if (stage_rst !== er)        begin errors++; $display("FAIL ack_ok_stage_rst edge=%0d got=%b exp=%b", n, stage_rst, er); end
         if (fault !== 3'b000)        begin errors++; $display("FAIL ack_ok_fault edge=%0d got=%b exp=000", n, fault); end
         if (sys_ready !== (n >= 36)) begin errors++; $display("FAIL ack_ok_sys_ready edge=%0d got=%b exp=%b", n, sys_ready, (n >= 36)); end
      end
      stage_ack = 3'b000;
      $display("test_ack_arrives done: stage_rst=%b fault=%b sys_ready=%b", stage_rst, fault, sys_ready);
   endtask
`endif

   initial begin
      test_reset();
      test_sequence();
      test_soft_in_run();
      test_soft_in_hold();
      test_async_mid();
`ifdef RESET_SEQ_ACK_WAIT_EN
      test_ack_timeout();
      test_ack_arrives();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Staged reset controller for the Pong FPGA design. Internally synchronizes release of the asynchronous board reset, then releases per-subsystem resets in a fixed order with programmable spacing: stage 0 VGA timing, stage 1 game logic, stage 2 score/display. Also services a synchronous soft-reset request, such as new-game/serve, and reports when the whole system is running.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs; 1..8.
HOLD_CYCLES, 16, clk cycles all stages stay in reset after the synchronized reset release; >=1.
GAP_CYCLES, 4, clk cycles between consecutive stage releases, and from the last release to sys_ready; >=1.
ACK_TIMEOUT, 1024, max clk cycles to wait for a stage ack; used only with ACK_WAIT_EN; > GAP_CYCLES.

Ports:
clk  input  1  system clock.
reset  input  1  reset, asynchronous, active-high.
soft_rst_req  input  1  synchronous single-cycle request to re-run the sequence.
stage_ack  input  NUM_STAGES  per-stage "came out of reset OK", level; used only with ACK_WAIT_EN.
stage_rst  output  NUM_STAGES  per-stage reset, active-high, registered.
sys_ready  output  1  high when all stages are released and the sequence is complete; registered.
busy  output  1  high in HOLD or RELEASE; registered.
fault  output  NUM_STAGES  sticky per-stage ack-timeout flags; registered.

Behaviour:
- Async reset:
  - While reset=1: stage_rst=all 1s, sys_ready=0, busy=1, fault=0, state=HOLD, counters=0.
  - Assertion takes effect immediately, with no clk needed.
- Release synchronizer:
  - Two-flop chain clears async on reset and shifts in 1 on each clk.
  - Internal rst_sync drops after the 2nd clk edge following reset deassertion.
  - Edges are numbered from 1 after deassert.
  - The FSM holds in HOLD with the counter at 0 while rst_sync=1.
- States HOLD, RELEASE, RUN; counters sized by $clog2.
- HOLD:
  - Counter increments each edge.
  - On reaching HOLD_CYCLES: clear stage_rst[0], index=0, counter=0, go to RELEASE.
  - Defaults: stage_rst[0] falls at edge 18.
- RELEASE:
  - Counter increments each edge.
  - When counter reaches GAP_CYCLES (plus the ack condition, see Optional Feature):
    - If index<NUM_STAGES-1: clear stage_rst[index+1], index++, counter=0.
    - Otherwise set sys_ready=1, busy=0, go to RUN.
  - Defaults: stage 1 falls at edge 22, stage 2 at edge 26, sys_ready rises at edge 30.
- Release order is strictly ascending. stage_rst bits never deassert out of order. A released stage is never re-asserted except via a reset or soft reset.
- RUN: outputs hold steady.
- soft_rst_req:
  - Sampled at a clk edge in RELEASE or RUN: all stage_rst=1, sys_ready=0, busy=1, counters=0, state=HOLD on that edge. The sequence then repeats from HOLD.
  - Ignored while in HOLD, with no counter restart.
  - fault is not cleared by soft reset.
- Async reset mid-sequence aborts immediately to the full reset values above, including fault=0.
- Simultaneous soft_rst_req and a stage-advance condition: soft reset wins.

Optional Feature:
Macro RESET_SEQ_ACK_WAIT_EN.
- Defined:
  - In RELEASE, advance requires counter>=GAP_CYCLES AND stage_ack[index]=1, sampled at the edge.
  - If the counter reaches ACK_TIMEOUT without the ack, set fault[index]=1 and advance anyway on that edge.
  - The counter saturates at ACK_TIMEOUT.
- Undefined:
  - stage_ack is ignored; advance occurs purely on GAP_CYCLES.
  - fault is tied to 0.
  - ACK_TIMEOUT is unused.

Test Plan:
- Defaults, reset held 5 cycles then released -> stage_rst 111 until edge 18, then 110 at 18, 100 at 22, 000 at 26; sys_ready=1 and busy=0 at edge 30.
- Reset re-asserted at edge 20 (mid RELEASE) -> stage_rst=111, sys_ready=0, busy=1 immediately without clk. After release the full timing repeats (stage0 at 18).
- In RUN, soft_rst_req pulse -> next edge stage_rst=111, sys_ready=0, busy=1. stage0 releases HOLD_CYCLES=16 edges later, sys_ready 28 edges after the request. fault is unchanged.
- soft_rst_req pulsed at edge 10 (HOLD) -> ignored; stage0 still releases at edge 18.
- ACK_WAIT_EN, stage_ack=3'b001, ACK_TIMEOUT=20 -> stage1 releases 4 edges after stage0. Stage 2 release occurs 20 edges after stage1 with fault=3'b010. sys_ready asserts after a further timeout, with fault=3'b110.
- ACK_WAIT_EN, stage_ack[1] rising 10 edges after stage1 release -> stage2 releases on that edge, fault stays 000.
